if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, issues one-outstanding-request fetches to instruction memory, and loads the IF/ID pipeline register. It consumes the branch decision Z produced by the ID-stage zero-test logic, plus jump and jr targets, and redirects the PC accordingly. Wrong-path instructions are squashed; there is no delay slot.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- Stall  in  1  hazard-unit freeze of PC and IF/ID; redirect inputs ignored while high
- Z  in  1  branch taken, from ID-stage zero test
- BranchAddr  in  32  branch target, valid when Z
- J  in  1  jump (j/jal) in ID
- JumpAddr  in  32  jump target
- JR  in  1  jr/jalr in ID
- JrAddr  in  32  forwarded Rs value
- imem_req  out  1  fetch request, one-cycle pulse
- imem_addr  out  32  fetch address, valid with imem_req
- imem_rvalid  in  1  response valid, ≥1 cycle after request
- imem_rdata  in  32  instruction word
- IF_ID_PC4  out  32  PC+4 of instruction in ID
- IF_ID_Instr  out  32  instruction in ID; 32'h0 (nop) on bubble/flush
- IF_ID_Valid  out  1  IF/ID holds a real instruction

## Operation
- Redirect = !Stall && (JR || J || Z). Priority JR > J > Z. Target is JrAddr, JumpAddr or BranchAddr, used unaligned-unchecked.
- Any redirect flushes IF/ID to {0, 32'h0, 0} and sets pc to the target.
- Stall holds pc and IF/ID. No request is issued while Stall is high.
- PC+4 is computed modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Bubble: whenever Stall is low and no instruction is accepted, IF/ID loads {0, 32'h0, 0}.
- FSM states:
  - IDLE: if !Stall && !redirect, imem_req=1, imem_addr=pc, go to WAIT. If redirect, load the target and stay IDLE. An imem_rvalid seen in IDLE is ignored.
  - WAIT (request outstanding):
    - Redirect: load the target. If rvalid arrives the same cycle, drop it and go to IDLE; otherwise go to DROP.
    - rvalid && Stall: capture rdata in the hold register and go to HOLD.
    - rvalid && !Stall: IF/ID gets {pc+4, rdata, 1}, pc gets pc+4, and the next request is issued in the same cycle (imem_req=1, imem_addr=pc+4). Stay in WAIT.
    - Otherwise: bubble, stay in WAIT.
  - DROP: wait for the stale response. Redirect loads a new target and stays in DROP. rvalid discards the data and goes to IDLE.
  - HOLD: when !Stall, IF/ID gets {pc+4, hold, 1}, pc gets pc+4, go to IDLE. Redirect discards hold and goes to IDLE.

## Timing
- Reset values:
  - Registers: pc=RESET_PC, state IDLE, IF_ID_PC4=0, IF_ID_Instr=0, IF_ID_Valid=0, hold=0.
  - Outputs: imem_req=0 during any cycle with rst_n low.
- Reset mid-fetch returns to IDLE. A late response is ignored.
- With 1-cycle memory, first instruction reaches IF/ID 2 cycles after reset release. Sustained throughput is 1 instruction/cycle.
- Taken branch penalty: 1 flushed slot, plus the discard cycle in DROP.
- imem_req/imem_addr are combinational from state, pc, Stall and redirect. IF/ID outputs are registered.

## Structure
- mips_pkg:
  - fetch-state enum {IDLE, WAIT, DROP, HOLD}
  - NOP_INSTR=32'h0
  - default RESET_PC
- Sub-module pc_next_sel: combinational redirect priority mux producing redirect and target. Everything else stays in if_fetch_stage.

## Test plan
- Reset release, 1-cycle memory returning 0x20080001, 0x20090002: imem_addr 0x0 then 0x4; IF/ID Valid=1 with PC4=0x4 then 0x8.
- Z=1, BranchAddr=0x100 in the cycle a response arrives: response dropped, IF/ID flushed to nop/Valid 0, next imem_addr=0x100.
- JR=1 and Z=1 together, JrAddr=0x200, BranchAddr=0x100: pc becomes 0x200.
- Stall high when rvalid arrives with 0x8C080000: state HOLD, IF/ID unchanged. On Stall low, IF/ID Instr=0x8C080000 and pc advances by 4.
- 3-cycle memory, J=1 to 0x40 while request outstanding: DROP state, stale rdata never enters IF/ID, then fetch at 0x40.
- rst_n low during WAIT, RESET_PC=0xBFC00000: pc=0xBFC00000, Valid=0; response arriving after reset is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS instruction-fetch
//                stage: fetch FSM states, IF/ID register layout, nop word,
//                default reset vector and the PC increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,   // no request outstanding
        FETCH_WAIT = 2'd1,   // request outstanding, response will be used
        FETCH_DROP = 2'd2,   // request outstanding, response will be discarded
        FETCH_HOLD = 2'd3    // response captured while stalled, waiting to enter IF/ID
    } fetch_state_t;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC, wrapping modulo 2^32
    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Redirect priority mux for the fetch stage. A redirect is only
//                raised when the pipeline is not frozen; jr beats j beats a
//                taken branch.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel (
    input  logic        Stall,
    input  logic        JR,
    input  logic        J,
    input  logic        Z,
    input  logic [31:0] JrAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] BranchAddr,
    output logic        redirect,
    output logic [31:0] target
);

    // Pick the highest-priority redirect source; frozen pipeline ignores all of them
    always_comb begin
        redirect = 1'b0;
        target   = BranchAddr;
        if (!Stall) begin
            if (JR) begin
                redirect = 1'b1;
                target   = JrAddr;
            end else if (J) begin
                redirect = 1'b1;
                target   = JumpAddr;
            end else if (Z) begin
                redirect = 1'b1;
                target   = BranchAddr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage of the 5-stage MIPS pipeline. Holds
//                the PC, runs one-outstanding-request fetches to instruction
//                memory, loads IF/ID and squashes wrong-path instructions on
//                branch / jump / jr redirects (no delay slot).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Z,
    input  logic [31:0] BranchAddr,
    input  logic        J,
    input  logic [31:0] JumpAddr,
    input  logic        JR,
    input  logic [31:0] JrAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
);

    localparam if_id_t c_ifIdBubble = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    fetch_state_t r_state;
    fetch_state_t w_nextState;
    logic [31:0]  r_pc;
    logic [31:0]  w_pcNext;
    logic [31:0]  w_pc4;
    if_id_t       r_ifId;
    if_id_t       w_ifIdNext;
    logic [31:0]  r_hold;
    logic [31:0]  w_holdNext;
    logic         w_redirect;
    logic [31:0]  w_target;

    pc_next_sel u_pcNextSel (
        .Stall      (Stall),
        .JR         (JR),
        .J          (J),
        .Z          (Z),
        .JrAddr     (JrAddr),
        .JumpAddr   (JumpAddr),
        .BranchAddr (BranchAddr),
        .redirect   (w_redirect),
        .target     (w_target)
    );

    assign w_pc4 = pcPlus4(r_pc);

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus next PC / IF/ID / hold values
    always_comb begin
        w_nextState = r_state;
        w_pcNext    = r_pc;
        w_ifIdNext  = r_ifId;
        w_holdNext  = r_hold;
        // Unfrozen cycles insert a bubble unless an instruction is accepted
        // below; a redirect is only possible when unfrozen, so this is also the flush.
        if (!Stall) begin
            w_ifIdNext = c_ifIdBubble;
        end
        if (w_redirect) begin
            w_pcNext = w_target;
        end
        case (r_state)
            FETCH_IDLE: begin
                // Any response seen here belongs to a request killed by reset
                if (!w_redirect && !Stall) begin
                    w_nextState = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (w_redirect) begin
                    w_nextState = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
                end else if (imem_rvalid && Stall) begin
                    w_holdNext  = imem_rdata;
                    w_nextState = FETCH_HOLD;
                end else if (imem_rvalid) begin
                    w_ifIdNext = '{pc4: w_pc4, instr: imem_rdata, valid: 1'b1};
                    w_pcNext   = w_pc4;
                end
            end
            FETCH_DROP: begin
                // A redirect arriving together with the stale response must
                // still leave DROP, otherwise nothing would ever answer again.
                if (imem_rvalid) begin
                    w_nextState = FETCH_IDLE;
                end
            end
            FETCH_HOLD: begin
                if (w_redirect) begin
                    w_nextState = FETCH_IDLE;
                end else if (!Stall) begin
                    w_ifIdNext  = '{pc4: w_pc4, instr: r_hold, valid: 1'b1};
                    w_pcNext    = w_pc4;
                    w_nextState = FETCH_IDLE;
                end
            end
            default: begin
                w_nextState = FETCH_IDLE;
            end
        endcase
    end

    // Memory request: new fetch from IDLE, or back-to-back fetch as a response lands
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        if (rst_n && !Stall && !w_redirect) begin
            case (r_state)
                FETCH_IDLE: begin
                    imem_req  = 1'b1;
                    imem_addr = r_pc;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        imem_req  = 1'b1;
                        imem_addr = w_pc4;
                    end
                end
                default: begin
                    imem_req  = 1'b0;
                    imem_addr = r_pc;
                end
            endcase
        end
    end

    // PC, IF/ID and hold registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_ifId <= c_ifIdBubble;
            r_hold <= 32'h0;
        end else begin
            r_pc   <= w_pcNext;
            r_ifId <= w_ifIdNext;
            r_hold <= w_holdNext;
        end
    end

    assign IF_ID_PC4   = r_ifId.pc4;
    assign IF_ID_Instr = r_ifId.instr;
    assign IF_ID_Valid = r_ifId.valid;

endmodule
`default_nettype wire
